// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC slave bridge: FSM state encoding,
// address tag width and the bus-stall timeout limit.
package fsmc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WRITE,
    READ,
    HOLD
  } fsmc_state_e;

  localparam int          TAG_WIDTH     = 2;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/fsmc_sync_edge.sv
// Purpose: synchronise one asynchronous host strobe and flag its rising/falling edges.
// Latency: level appears STAGES cycles after the pin; rise/fall pulse for one cycle with it.
// Backpressure: none, free-running; the pulse is lost if the consumer ignores it.
module fsmc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift chain resets to 1 (strobes idle high) so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/fsmc_slave_bridge.sv
// Purpose: FSMC multiplexed-bus slave turning host cycles into per-channel write/read strobes.
// Latency: strobes SYNC_STAGES+1 cycles after the host edge; read drive starts with rd_stb.
// Backpressure: none; the host paces everything. Optional macro FSMC_TIMEOUT_EN adds a stall timeout.
module fsmc_slave_bridge
  import fsmc_pkg::*;
#(
  parameter int                   ADDR_WIDTH       = 18,
  parameter int                   DATA_WIDTH       = 16,
  parameter int                   CH_NUM           = 4,
  parameter logic [TAG_WIDTH-1:0] TAG_VALUE        = 2'b01,
  parameter int                   SYNC_STAGES      = 2,
  parameter int                   DATA_HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  inout  wire  [ADDR_WIDTH-1:0]        AD,
  input  logic                         NADV,
  input  logic                         NWE,
  input  logic                         NOE,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [CH_NUM-1:0]            wr_stb,
  input  logic [CH_NUM*DATA_WIDTH-1:0] rd_data,
  output logic [CH_NUM-1:0]            rd_stb,
  output logic                         busy,
  output logic                         err
);

  localparam int CH_W = $clog2(CH_NUM);

  logic nadv_lvl, nadv_rise, nadv_fall;
  logic nwe_lvl, nwe_rise, nwe_fall;
  logic noe_lvl, noe_rise, noe_fall;

  fsmc_sync_edge #(.STAGES(SYNC_STAGES)) u_nadv (
    .clk(clk), .reset_n(reset_n), .din(NADV), .level(nadv_lvl), .rise(nadv_rise), .fall(nadv_fall)
  );
  fsmc_sync_edge #(.STAGES(SYNC_STAGES)) u_nwe (
    .clk(clk), .reset_n(reset_n), .din(NWE), .level(nwe_lvl), .rise(nwe_rise), .fall(nwe_fall)
  );
  fsmc_sync_edge #(.STAGES(SYNC_STAGES)) u_noe (
    .clk(clk), .reset_n(reset_n), .din(NOE), .level(noe_lvl), .rise(noe_rise), .fall(noe_fall)
  );

  fsmc_state_e            state;
  logic [ADDR_WIDTH-1:0]  ad_q;
  logic [ADDR_WIDTH-1:0]  drive_val;
  logic [ADDR_WIDTH-1:0]  rd_ext;
  logic [DATA_WIDTH-1:0]  rd_sel;
  logic [CH_W-1:0]        ch;
  logic                   dir;
  logic                   drive_en;
  logic                   ad_oe;
  logic [2:0]             hold_cnt;
  logic                   tag_ok;
  logic                   tmo_hit;

  // Levels and some edges are not needed by the decision logic.
  logic unused_sigs;
  assign unused_sigs = ^{nadv_lvl, nadv_fall, nwe_fall, noe_lvl};

  // Registered copy of the bus: every decision looks at this, never at the raw pins.
  always_ff @(posedge clk) begin
    if (!reset_n) ad_q <= '0;
    else          ad_q <= AD;
  end

  assign tag_ok = (ad_q[ADDR_WIDTH-1 -: TAG_WIDTH] == TAG_VALUE);
  assign rd_sel = rd_data[ch*DATA_WIDTH +: DATA_WIDTH];

  // Zero-extend the selected read channel to the full bus width.
  always_comb begin
    rd_ext                 = '0;
    rd_ext[DATA_WIDTH-1:0] = rd_sel;
  end

  // A new address phase or reset drops the drive immediately, before the FSM register updates.
  assign ad_oe = drive_en & reset_n & ~nadv_rise;
  assign AD    = ad_oe ? drive_val : {ADDR_WIDTH{1'bz}};

`ifdef FSMC_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        any_edge;

  assign any_edge = nadv_rise | nadv_fall | nwe_rise | nwe_fall | noe_rise | noe_fall;
  assign tmo_hit  = (tmo_cnt == TIMEOUT_LIMIT);

  // Stall counter: runs while waiting on the host, restarts on any strobe activity.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state == ADDR || state == WRITE || state == READ) && !any_edge && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction FSM with registered strobes, drive enable, busy and sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ch        <= '0;
      dir       <= 1'b0;
      wr_data   <= '0;
      wr_stb    <= '0;
      rd_stb    <= '0;
      drive_en  <= 1'b0;
      drive_val <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_stb <= '0;
      rd_stb <= '0;
      if (state == READ || state == HOLD) drive_val <= rd_ext;

      if (nadv_rise) begin
        // Fresh address phase; anything in flight is abandoned and flagged.
        if (state != IDLE) err <= 1'b1;
        drive_en <= 1'b0;
        if (tag_ok) begin
          state <= ADDR;
          busy  <= 1'b1;
          ch    <= ad_q[CH_W-1:0];
          dir   <= nwe_lvl;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else if (tmo_hit) begin
        state    <= IDLE;
        busy     <= 1'b0;
        drive_en <= 1'b0;
        err      <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ADDR: state <= dir ? READ : WRITE;
          WRITE: begin
            if (nwe_rise) begin
              wr_data    <= ad_q[DATA_WIDTH-1:0];
              wr_stb[ch] <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
          READ: begin
            if (noe_fall && !drive_en) begin
              rd_stb[ch] <= 1'b1;
              drive_en   <= 1'b1;
            end else if (noe_rise && drive_en) begin
              state    <= HOLD;
              hold_cnt <= 3'(DATA_HOLD_CYCLES - 1);
            end
          end
          HOLD: begin
            if (hold_cnt == 3'd0) begin
              drive_en <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 3'd1;
            end
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            drive_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fsmc_slave_bridge.md
FSMC_SLAVE_BRIDGE -- requirements
Module: fsmc_slave_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 18, width of the multiplexed AD bus.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width; must be ≤ ADDR_WIDTH.
REQ-003 SHALL have parameter CH_NUM, default 4, number of channels; power of two, 2..16.
REQ-004 SHALL have parameter TAG_VALUE, default 2'b01, value required in AD[ADDR_WIDTH-1 -: 2] for a valid address.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, depth of the NADV/NWE/NOE synchroniser (2..3).
REQ-006 SHALL have parameter DATA_HOLD_CYCLES, default 2, number of cycles AD stays driven after NOE deassert (1..7).
REQ-007 SHALL have ports clk (in, 1, sole clock) and reset_n (in, 1, synchronous active-low reset), listed first.
REQ-008 SHALL have ports AD (inout, ADDR_WIDTH, muxed addr/data), NADV, NWE and NOE (in, 1 each, active low).
REQ-009 SHALL have ports wr_data (out, DATA_WIDTH, host write data) and wr_stb (out, CH_NUM, one-hot 1-cycle write strobe).
REQ-010 SHALL have ports rd_data (in, CH_NUM*DATA_WIDTH, per-channel read data, channel i at slice i) and rd_stb (out, CH_NUM, one-hot 1-cycle read strobe).
REQ-011 SHALL have ports busy (out, 1, transaction active) and err (out, 1, sticky error flag).

Function
REQ-012 SHALL pass NADV/NWE/NOE through SYNC_STAGES flops and register AD once per cycle; all decisions use the synchronised strobes and the registered AD.
REQ-013 SHALL run a FSM with states IDLE, ADDR, WRITE, READ and HOLD.
REQ-014 IDLE→ADDR on NADV rising edge when the tag matches; it latches ch = AD[$clog2(CH_NUM)-1:0] and dir = NWE (1 = read).
REQ-015 On a NADV rising edge with a tag mismatch, it SHALL stay in IDLE with no strobe and no drive.
REQ-016 From ADDR, dir=0 SHALL go to WRITE; on NWE rising edge it captures AD[DATA_WIDTH-1:0] into wr_data, pulses wr_stb[ch] for exactly 1 cycle in the same cycle wr_data updates, and returns to IDLE.
REQ-017 From ADDR, dir=1 SHALL go to READ; on NOE falling edge it pulses rd_stb[ch] for 1 cycle and enables the AD drive from the next cycle.
REQ-018 In READ the drive value SHALL be zero-extended rd_data slice ch, re-registered every cycle while driving.
REQ-019 On NOE rising edge in READ, it SHALL go to HOLD, keep driving for DATA_HOLD_CYCLES cycles, release AD to Z, then return to IDLE.
REQ-020 In any non-IDLE state, a new NADV rising edge SHALL abort the current transaction: drive released the same cycle, no strobe issued, err set, then processed as a fresh address phase.
REQ-021 Simultaneous NWE and NOE edges in one cycle SHALL be handled by dir only; the other edge is ignored.
REQ-022 busy SHALL be 1 in every state except IDLE; at most one bit of wr_stb|rd_stb is high in any cycle.

Reset
REQ-023 With reset_n low at a clk edge: FSM→IDLE, drive off (AD=Z), wr_data=0, wr_stb=0, rd_stb=0, busy=0, err=0, synchroniser flops=1.
REQ-024 A reset asserted mid-transaction SHALL abandon it without issuing any strobe; AD is Z from the first reset cycle.

Configuration
REQ-025 With FSMC_TIMEOUT_EN defined, a 16-bit counter SHALL run in ADDR/WRITE/READ and reload on any strobe edge; at 0xFFFF it forces IDLE, releases AD and sets err.
REQ-026 Without FSMC_TIMEOUT_EN there SHALL be no counter logic, non-IDLE states wait indefinitely, and err is set only by REQ-020.

Structure
REQ-027 Package fsmc_pkg SHALL hold the FSM state enum (fsmc_state_e), the tag-width constant and the timeout limit constant.
REQ-028 The synchroniser plus edge detector SHALL be sub-module fsmc_sync_edge (one instance per strobe, outputs rise/fall pulses).

Verification
REQ-029 Write ch2, data 0xA5C3 -> wr_data=0xA5C3 and wr_stb=4'b0100 for 1 cycle, busy back to 0.
REQ-030 Read ch1 with rd_data slice1=0x1234 -> rd_stb=4'b0010 once; AD reads 0x01234 while NOE low and for 2 cycles after, then Z.
REQ-031 Address with tag 2'b10 followed by an NWE pulse -> no wr_stb, no drive, err stays 0.
REQ-032 Second NADV mid-READ -> AD released the same cycle, err=1, the new transaction completes normally.
REQ-033 reset_n low during READ drive -> AD=Z, all outputs at reset values the next cycle.
REQ-034 FSMC_TIMEOUT_EN defined, ADDR with no NWE/NOE for 65535 cycles -> IDLE, err=1, busy=0.
